// File: rtl/req_encoder8to3_pkg.sv
// Shared types and constants for the 8-to-3 request encoder and its priority picker.
package req_encoder8to3_pkg;

   localparam int REQ_W  = 8;
   localparam int CODE_W = 3;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   function automatic logic [REQ_W-1:0] code2onehot(input logic [CODE_W-1:0] code);
      return REQ_W'(1) << code;
   endfunction

endpackage

// File: rtl/req_encoder8to3_rr_pick8.sv
// Combinational priority pick over eight pending bits: fixed (lowest index) or
// round-robin starting at the pointer and wrapping 7 -> 0.
module rr_pick8
   import req_encoder8to3_pkg::*;
(
   input  logic [REQ_W-1:0]  pending_i,
   input  logic [CODE_W-1:0] ptr_i,
   input  logic              rr_en_i,
   output logic              found_o,
   output logic [CODE_W-1:0] idx_o
);

   logic [CODE_W-1:0] base;
   logic [CODE_W-1:0] cand;

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      cand    = '0;
      base    = rr_en_i ? ptr_i : '0;
      // Walk from the farthest candidate back to the base; the last hit is the
      // closest one to the base, and the 3-bit add wraps 7 -> 0 for free.
      for (int k = REQ_W - 1; k >= 0; k--) begin
         cand = base + CODE_W'(k);
         if (pending_i[cand]) begin
            found_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/req_encoder8to3.sv
// Registered 8-to-3 request encoder: accumulates request lines into a pending
// register and presents one index at a time under a valid/ack handshake.
module req_encoder8to3
   import req_encoder8to3_pkg::*;
#(
   parameter bit RR_EN = 1'b1
)(
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic [REQ_W-1:0]  Req_in,
   input  logic              Ack_in,
   output logic [CODE_W-1:0] Code_out,
   output logic              Valid_out,
   output logic [REQ_W-1:0]  Pending_out,
   output logic              Overflow_out
);

   state_t            state_q, state_d;
   logic [REQ_W-1:0]  pending_q, pending_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic [CODE_W-1:0] ptr_q, ptr_d;
   logic              overflow_q, overflow_d;

   logic              ack_eff;
   logic [REQ_W-1:0]  clr;
   logic              pick_found;
   logic [CODE_W-1:0] pick_idx;

   // Selection sees only the registered pending value, never same-cycle requests.
   rr_pick8 u_pick (
      .pending_i (pending_q),
      .ptr_i     (ptr_q),
      .rr_en_i   (RR_EN),
      .found_o   (pick_found),
      .idx_o     (pick_idx)
   );

   assign ack_eff = (state_q == PRESENT) && Ack_in;

   always_comb begin
      clr        = ack_eff ? code2onehot(code_q) : '0;
      // Set wins over clear: a fresh request on the acked bit is a new event.
      pending_d  = (pending_q & ~clr) | Req_in;
      overflow_d = |(Req_in & pending_q & ~clr);
   end

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               code_d  = pick_idx;
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (Ack_in) begin
               ptr_d   = code_q + CODE_W'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q    <= IDLE;
         pending_q  <= '0;
         code_q     <= '0;
         ptr_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         code_q     <= code_d;
         ptr_q      <= ptr_d;
         overflow_q <= overflow_d;
      end
   end

   assign Code_out     = code_q;
   assign Valid_out    = (state_q == PRESENT);
   assign Pending_out  = pending_q;
   assign Overflow_out = overflow_q;

endmodule

// File: tb/tb_req_encoder8to3.sv
// Scoreboard bench: a fixed-priority and a round-robin encoder share stimulus;
// a behavioural model predicts per-cycle status and grant codes for both.
module tb_req_encoder8to3;

   typedef struct packed {
      logic [7:0] pend;
      logic [2:0] code;
      logic       valid;
      logic       ov;
   } st_t;

   logic       Clk;
   logic       Rst_n;
   logic [7:0] Req_in;
   logic       Ack_in;

   logic [2:0] fx_code, rr_code;
   logic       fx_valid, rr_valid;
   logic [7:0] fx_pend, rr_pend;
   logic       fx_ov, rr_ov;

   int checks   = 0;
   int failures = 0;
   int ov_cnt   = 0;

   // index 0 = fixed priority instance, index 1 = round-robin instance
   logic [7:0] mp [2];
   logic       mv [2];
   int         mc [2];
   int         mptr [2];
   logic       mo [2];
   st_t        sq [2][$];
   int         gq [2][$];
   int         obs [2][$];
   logic       prev_v [2];

   req_encoder8to3 #(.RR_EN(1'b0)) dut_fx (
      .Clk(Clk), .Rst_n(Rst_n), .Req_in(Req_in), .Ack_in(Ack_in),
      .Code_out(fx_code), .Valid_out(fx_valid), .Pending_out(fx_pend), .Overflow_out(fx_ov)
   );

   req_encoder8to3 #(.RR_EN(1'b1)) dut_rr (
      .Clk(Clk), .Rst_n(Rst_n), .Req_in(Req_in), .Ack_in(Ack_in),
      .Code_out(rr_code), .Valid_out(rr_valid), .Pending_out(rr_pend), .Overflow_out(rr_ov)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int m = 0; m < 2; m++) begin
         mp[m] = 8'h00; mv[m] = 1'b0; mc[m] = 0; mptr[m] = 0; mo[m] = 1'b0;
      end
   endtask

   // One clock edge of the reference behaviour, applied to both modes.
   task automatic model_edge(input logic [7:0] req, input logic ack, input logic rst_v);
      for (int m = 0; m < 2; m++) begin
         st_t        s;
         logic       ack_eff;
         logic       found;
         int         pick;
         int         base;
         int         idx;
         logic [7:0] np;
         logic       ov;
         logic       cleared;
         if (!rst_v) begin
            mp[m] = 8'h00; mv[m] = 1'b0; mc[m] = 0; mptr[m] = 0; mo[m] = 1'b0;
         end else begin
            ack_eff = mv[m] && ack;
            ov = 1'b0;
            np = 8'h00;
            for (int i = 0; i < 8; i++) begin
               cleared = ack_eff && (i == mc[m]);
               np[i] = req[i] || (mp[m][i] && !cleared);
               if (req[i] && mp[m][i] && !cleared) ov = 1'b1;
            end
            found = 1'b0;
            pick = 0;
            if (!mv[m]) begin
               base = (m == 1) ? mptr[m] : 0;
               for (int k = 0; k < 8; k++) begin
                  idx = (base + k) % 8;
                  if (!found && mp[m][idx]) begin
                     found = 1'b1;
                     pick = idx;
                  end
               end
            end
            if (found) begin
               mv[m] = 1'b1;
               mc[m] = pick;
               gq[m].push_back(pick);
            end else if (ack_eff) begin
               mv[m] = 1'b0;
               mptr[m] = (mc[m] + 1) % 8;
            end
            mp[m] = np;
            mo[m] = ov;
         end
         s.pend = mp[m];
         s.code = 3'(mc[m]);
         s.valid = mv[m];
         s.ov = mo[m];
         sq[m].push_back(s);
      end
   endtask

   task automatic step(input logic [7:0] req, input logic ack);
      Req_in = req;
      Ack_in = ack;
      @(posedge Clk);
      model_edge(req, ack, Rst_n);
      #1;
   endtask

   task automatic mon(input int m, input logic [7:0] pend, input logic [2:0] code,
                      input logic valid, input logic ov);
      st_t s;
      if (sq[m].size() > 0) begin
         s = sq[m].pop_front();
         check($sformatf("pending[%0d]", m), 32'(pend), 32'(s.pend));
         check($sformatf("valid[%0d]", m), 32'(valid), 32'(s.valid));
         check($sformatf("overflow[%0d]", m), 32'(ov), 32'(s.ov));
         if (s.valid) check($sformatf("code[%0d]", m), 32'(code), 32'(s.code));
      end
      if (valid && !prev_v[m]) begin
         if (gq[m].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_grant[%0d]: got code=%0d expected no grant at t=%0t", m, code, $time);
         end else begin
            check($sformatf("grant_code[%0d]", m), 32'(code), 32'(gq[m].pop_front()));
         end
         obs[m].push_back(int'(code));
      end
      if (m == 1 && ov) ov_cnt++;
      prev_v[m] = valid;
   endtask

   initial begin
      prev_v[0] = 1'b0;
      prev_v[1] = 1'b0;
   end

   always @(negedge Clk) begin
      mon(0, fx_pend, fx_code, fx_valid, fx_ov);
      mon(1, rr_pend, rr_code, rr_valid, rr_ov);
   end

   task automatic check_seq(input string name, input int m, input int e[$]);
      check({name, "_len"}, 32'(obs[m].size()), 32'(e.size()));
      if (obs[m].size() == e.size())
         for (int i = 0; i < e.size(); i++)
            check(name, 32'(obs[m][i]), 32'(e[i]));
   endtask

   task automatic clear_obs();
      obs[0].delete();
      obs[1].delete();
   endtask

   initial begin
      int e[$];
      model_clear();
      Rst_n  = 1'b0;
      Req_in = 8'hFF;
      Ack_in = 1'b0;
      #1;
      check("rst_valid_fx", 32'(fx_valid), 32'd0);
      check("rst_pend_rr", 32'(rr_pend), 32'd0);
      check("rst_code_rr", 32'(rr_code), 32'd0);
      check("rst_ov_rr", 32'(rr_ov), 32'd0);

      // Requests held through reset are ignored until release.
      repeat (3) step(8'hFF, 1'b0);
      Rst_n = 1'b1;
      step(8'hFF, 1'b0);
      check("release_pend", 32'(rr_pend), 32'hFF);
      step(8'h00, 1'b0);
      check("release_valid", 32'(rr_valid), 32'd1);
      check("release_code", 32'(rr_code), 32'd0);
      repeat (20) step(8'h00, 1'b1);

      // Round-robin ordering with pointer wrap after code 7.
      clear_obs();
      step(8'h85, 1'b0);
      repeat (8) step(8'h00, 1'b1);
      e = '{0, 2, 7};
      check_seq("rr_seq_85", 1, e);
      check_seq("fx_seq_85", 0, e);

      // Request raised during PRESENT only accumulates.
      clear_obs();
      step(8'h14, 1'b0);
      step(8'h00, 1'b0);
      step(8'h02, 1'b0);
      repeat (8) step(8'h00, 1'b1);
      e = '{2, 1, 4};
      check_seq("fx_seq_late", 0, e);
      e = '{2, 4, 1};
      check_seq("rr_seq_late", 1, e);

      // Ack and re-request of the presented bit in the same cycle.
      clear_obs();
      ov_cnt = 0;
      step(8'h08, 1'b0);
      step(8'h00, 1'b0);
      step(8'h08, 1'b1);
      repeat (2) step(8'h00, 1'b0);
      step(8'h00, 1'b1);
      repeat (2) step(8'h00, 1'b0);
      e = '{3, 3};
      check_seq("rr_reack", 1, e);
      check("reack_no_overflow", 32'(ov_cnt), 32'd0);

      // Duplicate pulses on a pending, non-presented bit.
      clear_obs();
      ov_cnt = 0;
      step(8'h0A, 1'b0);
      step(8'h00, 1'b0);
      step(8'h08, 1'b0);
      step(8'h00, 1'b0);
      step(8'h08, 1'b0);
      step(8'h00, 1'b0);
      repeat (6) step(8'h00, 1'b1);
      check("overflow_pulses", 32'(ov_cnt), 32'd2);
      e = '{1, 3};
      check_seq("rr_dup3", 1, e);

      // Asynchronous reset mid-handshake.
      step(8'h40, 1'b0);
      step(8'h00, 1'b0);
      @(negedge Clk);
      #2;
      Rst_n = 1'b0;
      #1;
      check("async_valid_rr", 32'(rr_valid), 32'd0);
      check("async_pend_rr", 32'(rr_pend), 32'd0);
      check("async_valid_fx", 32'(fx_valid), 32'd0);
      check("async_pend_fx", 32'(fx_pend), 32'd0);
      model_clear();
      repeat (2) step(8'h00, 1'b0);
      Rst_n = 1'b1;
      clear_obs();
      repeat (5) step(8'h00, 1'b0);
      check("no_grant_after_rst", 32'(obs[1].size() + obs[0].size()), 32'd0);

      // Random traffic against the reference model.
      repeat (400) begin
         logic [7:0] r;
         r = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
         step(r, 1'($urandom_range(0, 1)));
      end
      repeat (24) step(8'h00, 1'b1);
      @(negedge Clk);
      #1;
      check("grants_drained_fx", 32'(gq[0].size()), 32'd0);
      check("grants_drained_rr", 32'(gq[1].size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/req_encoder8to3.md
# req_encoder8to3

Registered 8-to-3 request encoder: the inverse of the team's 3-to-8 one-hot decoder. Latches up to eight independent request lines into a pending register, selects one pending bit (fixed or round-robin priority), and presents its 3-bit index with a valid/ack handshake. Sits between request sources (interrupt lines, per-channel strobes) and a consumer that handles one indexed event at a time. Feeding `Code_out` back through the 3-to-8 decoder reproduces the granted pending bit.

## Interface
- `RR_EN`, default 1: 1 = round-robin selection; 0 = fixed priority, lowest index wins.
- `Clk`  in  1  single clock; all state changes on its rising edge.
- `Rst_n`  in  1  reset, asynchronous, active-low.
- `Req_in`  in  8  request lines; bit i high in a cycle sets pending[i].
- `Ack_in`  in  1  consumer accepts the presented code; ignored while `Valid_out`=0.
- `Code_out`  out  3  index of the presented request; stable while `Valid_out`=1.
- `Valid_out`  out  1  `Code_out` holds a pending, unacknowledged request.
- `Pending_out`  out  8  current pending register.
- `Overflow_out`  out  1  one-cycle pulse: a request arrived on a bit already pending and not being cleared that cycle.

## Operation
- Reset values: pending=0, `Code_out`=3'b000, `Valid_out`=0, `Overflow_out`=0, rr pointer=0, state IDLE.
- Pending update each edge: pending_next = (pending & ~clr) | `Req_in`. clr has only bit `Code_out` set, and only when `Valid_out` & `Ack_in`; otherwise clr=0.
- Set wins over clear: `Req_in[Code_out]`=1 in the ack cycle leaves that bit pending (a new event).
- `Overflow_out` next = |(`Req_in` & pending & ~clr).
- FSM, two states:
  - IDLE: if registered pending != 0, register the selected index into `Code_out`, set `Valid_out`=1, go to PRESENT; else stay.
  - PRESENT: hold `Code_out` and `Valid_out`. On `Ack_in`=1: clear pending[`Code_out`], drop `Valid_out`, update the pointer, go to IDLE.
- Selection uses the registered pending value only. A same-cycle `Req_in` is not visible to selection.
- Fixed mode: lowest set index of pending wins.
- Round-robin mode: search upward from the pointer, wrapping 7→0. On ack, pointer = `Code_out`+1 mod 8, so 7 wraps to 0. A source granted last has lowest priority next.
- Requests arriving during PRESENT only accumulate; the presented code never changes before ack.

## Timing
- `Req_in[i]` high before edge k → pending[i]=1 after k → `Valid_out`=1 with `Code_out`=i after k+1, if idle and i is selected.
- Ack at edge m → `Valid_out`=0 after m → next grant valid after m+1. Throughput is one grant per 2 cycles minimum; the IDLE bubble is intentional.
- `Overflow_out` is registered, one cycle after the offending `Req_in`.
- `Rst_n` low mid-handshake: all state clears immediately, independent of `Clk`. Pending requests are lost.

## Structure
- Shared package holds:
  - state enum {IDLE, PRESENT};
  - `REQ_W`=8 and `CODE_W`=3 constants;
  - a function returning one-hot from code, for checks.
- One natural sub-module, `rr_pick8`: combinational pick of (pending, pointer, mode) → {found, index}. It makes the two priority modes unit-testable.

## Test plan
- Reset with `Req_in`=8'hFF held → all outputs zero while `Rst_n`=0. After release: pending=8'hFF at the first edge, `Valid_out`=1 with `Code_out`=0 at the second.
- `RR_EN`=1, pending=8'b1000_0101, ack each grant → codes 0, 2, 7 in order. The pointer wraps to 0 after code 7.
- `RR_EN`=0, `Req_in`=8'b0001_0100 pulsed once, then `Req_in[1]` raised during PRESENT of code 2 → grants 2, then 1, then 4.
- `Ack_in`=1 with `Req_in[Code_out]`=1 in the same cycle → that bit stays pending, `Overflow_out`=0, and the same code is re-presented after the bubble.
- `Req_in[3]` pulsed twice while pending[3]=1 and not presented → `Overflow_out` pulses once per extra pulse, one cycle later. Only one grant of code 3 results.
- `Rst_n` asserted during PRESENT with `Ack_in` low → `Valid_out`=0 and pending=0 without a clock edge. No grant appears after release.
